// File: rtl/eeg_sample_loader.sv
// eeg_sample_loader: streams one epoch of ADC samples as Q20 words into int-res memory through a 2-entry FIFO.
// Define EEG_LOADER_OVERRUN_CHECK_EN to swallow post-epoch samples and flag them on a sticky overrun output.
module eeg_sample_loader #(
    parameter int NUM_SAMPLES = 3840,
    parameter int BASE_ADDR   = 0,
    parameter int FRAC_SHIFT  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic        adc_ready,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [15:0] mem_addr,
    output logic [29:0] mem_data,
    output logic        mem_width,
    output logic        busy,
`ifdef EEG_LOADER_OVERRUN_CHECK_EN
    output logic        overrun,
`endif
    output logic        done
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    typedef enum logic [1:0] {IDLE, LOADING, DRAIN, DONE} state_t;
    state_t state;
    logic [CW-1:0] acc_cnt, wr_cnt;
    logic [1:0] fifo_cnt;
    logic [29:0] head, tail, conv;
    logic [15:0] s16;
    logic go, load_ready, push, pop;
    assign s16 = adc_data ^ 16'h8000;
    assign conv = {{14{s16[15]}}, s16} << FRAC_SHIFT;
    assign go = start && (state == IDLE || state == DONE);
    assign load_ready = state == LOADING && fifo_cnt != 2'd2 && acc_cnt < CW'(NUM_SAMPLES);
    assign push = adc_valid && load_ready;
    assign pop = mem_req && mem_gnt;
    assign mem_req = fifo_cnt != 2'd0;
    assign mem_data = head;
    assign mem_addr = 16'(BASE_ADDR) + 16'(wr_cnt);
    assign mem_width = 1'b1;
    assign busy = state == LOADING || state == DRAIN;
    assign done = state == DRAIN && pop && wr_cnt == CW'(NUM_SAMPLES - 1);
`ifdef EEG_LOADER_OVERRUN_CHECK_EN
    assign adc_ready = load_ready || state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else if (go) overrun <= 1'b0;
        else if (state == DONE && adc_valid) overrun <= 1'b1;
    end
`else
    assign adc_ready = load_ready;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            fifo_cnt <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (go) begin
            state    <= LOADING;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            fifo_cnt <= '0;
        end else begin
            acc_cnt  <= acc_cnt + CW'(push);
            wr_cnt   <= wr_cnt + CW'(pop);
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
            // push with pop only happens at occupancy 1, so the new sample becomes the head directly
            if (pop) head <= push ? conv : tail;
            else if (push && fifo_cnt == 2'd0) head <= conv;
            if (push && !pop && fifo_cnt == 2'd1) tail <= conv;
            if (push && acc_cnt == CW'(NUM_SAMPLES - 1)) state <= DRAIN;
            if (done) state <= DONE;
        end
    end
endmodule

// File: tb/tb_eeg_sample_loader.sv
// tb_eeg_sample_loader: scoreboard bench for eeg_sample_loader with a queue-based reference model.
module tb_eeg_sample_loader;
    localparam int N = 3840;
    logic clk = 0, rst_n = 0, start = 0, adc_valid = 0, mem_gnt = 0;
    logic [15:0] adc_data = 0;
    logic adc_ready, mem_req, mem_width, busy, done;
    logic [15:0] mem_addr;
    logic [29:0] mem_data;
`ifdef EEG_LOADER_OVERRUN_CHECK_EN
    logic overrun;
`endif
    typedef struct {logic [15:0] addr; logic [29:0] data;} wr_t;
    wr_t exp_q[$];
    int compared = 0, mismatched = 0;
    int cyc = 0, acc_n = 0, gnt_n = 0, run_cnt = 0, done_n = 0, mon_wr = 0;
    int start_cyc = 0, first_acc_cyc = 0, done_cyc = 0;
    bit in_run = 0, after_done = 0, held = 0;
    logic [15:0] h_addr;
    logic [29:0] h_data;
    logic [15:0] sdat[3] = '{16'h0000, 16'h8000, 16'hFFFF};
    logic [29:0] sexp[3] = '{30'h3FF00000, 30'h0, 30'h000FFFE0};

    eeg_sample_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
        .adc_ready(adc_ready), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_width(mem_width), .busy(busy),
`ifdef EEG_LOADER_OVERRUN_CHECK_EN
        .overrun(overrun),
`endif
        .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [29:0] q20(input logic [15:0] d);
        int v = (int'(d) - 32768) * 32;
        return v[29:0];
    endfunction

    // stimulus-side model: expected ready, accepted samples into the scoreboard
    always @(negedge clk) begin
        bit exp_ready;
        if (!rst_n) begin
            acc_n = 0; gnt_n = 0; in_run = 0; after_done = 0;
        end else begin
            exp_ready = in_run && (acc_n - gnt_n) < 2 && acc_n < N;
`ifdef EEG_LOADER_OVERRUN_CHECK_EN
            exp_ready = exp_ready || after_done;
`endif
            check("adc_ready", adc_ready, exp_ready);
            if (adc_valid && adc_ready && in_run) begin
                if (acc_n == 0) first_acc_cyc = cyc;
                exp_q.push_back('{16'(acc_n), q20(adc_data)});
                acc_n++;
            end
            if (mem_req && mem_gnt) gnt_n++;
            if (start && !in_run) begin
                in_run = 1; after_done = 0; acc_n = 0; gnt_n = 0; run_cnt++; start_cyc = cyc;
            end else if (in_run && gnt_n == N) begin
                in_run = 0; after_done = 1;
            end
        end
    end

    // monitor: pops the scoreboard on every granted write
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            exp_q.delete(); held = 0; mon_wr = 0;
        end else begin
            if (held) begin
                check("hold_req", mem_req, 1);
                check("hold_addr", mem_addr, h_addr);
                check("hold_data", mem_data, h_data);
            end
            held = mem_req && !mem_gnt;
            h_addr = mem_addr;
            h_data = mem_data;
            if (mem_req && mem_gnt) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_data, e.data);
                end
                if (run_cnt == 1 && mon_wr < 3) check("q20_const", mem_data, sexp[mon_wr]);
                mon_wr++;
                check("done_last", done, mon_wr == N);
                if (mon_wr == N) mon_wr = 0;
            end else check("done_idle", done, 0);
            if (done) begin done_n++; done_cyc = cyc; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_epoch(input bit rnd, input bit spec, input int start_at, input int rst_at);
        int budget = 20000;
        int d0 = done_n;
        bit sent = 0;
        adc_valid = 1; adc_data = 16'h1234; mem_gnt = 1; start = 1;
        tick();
        start = 0;
        while (done_n == d0 && budget > 0) begin
            if (rst_at >= 0 && acc_n >= rst_at) begin
                rst_n = 0; adc_valid = 0;
                tick(); tick();
                check("reset_req", mem_req, 0);
                check("reset_addr", mem_addr, 0);
                check("no_done_abort", done_n, d0);
                rst_n = 1;
                tick();
                return;
            end
            mem_gnt = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            adc_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            adc_data = (spec && acc_n < 3) ? sdat[acc_n] : 16'($urandom);
            start = (!sent && acc_n == start_at);
            sent = sent || start;
            tick();
            budget--;
        end
        start = 0;
        if (budget == 0) begin
            compared++; mismatched++;
            $display("FAIL epoch_timeout: got no done, required done within 20000 cycles");
        end
        check("busy_after_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        check("accepted_total", acc_n, N);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_adc_ready", adc_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_mem_width", mem_width, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef EEG_LOADER_OVERRUN_CHECK_EN
        check("rst_overrun", overrun, 0);
`endif
        rst_n = 1;
        tick();
        run_epoch(0, 1, -1, -1);
        check("accept_after_start", first_acc_cyc - start_cyc, 1);
        check("done_latency", done_cyc - first_acc_cyc, N);
        run_epoch(1, 0, 100, -1);
        run_epoch(1, 0, -1, 2000);
        run_epoch(0, 0, -1, -1);
        check("done_count", done_n, 3);
        mem_gnt = 1; adc_valid = 1;
        repeat (5) begin
            adc_data = 16'($urandom);
            tick();
        end
        adc_valid = 0;
        tick();
        check("no_extra_accepts", acc_n, N);
`ifdef EEG_LOADER_OVERRUN_CHECK_EN
        check("overrun_set", overrun, 1);
        start = 1;
        tick();
        start = 0;
        check("overrun_clear", overrun, 0);
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
